// File: rtl/eth_fcs_insert.sv
// Avalon-ST Ethernet FCS inserter: forwards frames and appends the IEEE 802.3 CRC-32.
// Define ETH_PAD_EN to zero-pad frames shorter than MIN_FRAME_BYTES before the FCS.
module eth_fcs_insert #(
    parameter int MIN_FRAME_BYTES = 60
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] in_data,
    input  logic        in_startofpacket,
    input  logic        in_endofpacket,
    input  logic        in_valid,
    input  logic [1:0]  in_empty,
    output logic        in_ready,
    output logic [31:0] out_data,
    output logic        out_startofpacket,
    output logic        out_endofpacket,
    output logic [1:0]  out_empty,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] frame_count
);

`ifdef ETH_PAD_EN
    localparam bit PAD_EN = 1'b1;
`else
    localparam bit PAD_EN = 1'b0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_PASS, S_PAD, S_FCS} state_t;

    // Reflected CRC-32, one byte, LSB first.
    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
        return r;
    endfunction

    function automatic logic [31:0] crc_word(input logic [31:0] c, input logic [31:0] w,
                                             input logic [2:0] n);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 4; i++)
            if (i < int'(n)) r = crc_byte(r, w[31-8*i -: 8]);
        return r;
    endfunction

    function automatic logic [31:0] keep_bytes(input logic [31:0] w, input logic [2:0] n);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 4; i++)
            if (i < int'(n)) r[31-8*i -: 8] = w[31-8*i -: 8];
        return r;
    endfunction

    // Fill lanes n..3 with the leading FCS bytes (fcs[7:0] goes out first).
    function automatic logic [31:0] merge_fcs(input logic [31:0] w, input logic [2:0] n,
                                              input logic [31:0] f);
        logic [31:0] r;
        r = w;
        for (int i = 0; i < 4; i++)
            if (i >= int'(n)) r[31-8*i -: 8] = f[8*(i-int'(n)) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] fcs_beat(input logic [31:0] f, input logic [2:0] rem);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 4; i++)
            if (i < int'(rem)) r[31-8*i -: 8] = f[8*(4-int'(rem)+i) +: 8];
        return r;
    endfunction

    function automatic logic [10:0] sat_add(input logic [10:0] c, input logic [2:0] n);
        logic [11:0] s;
        s = {1'b0, c} + {9'h0, n};
        return s[11] ? 11'h7FF : s[10:0];
    endfunction

    state_t      state_q, state_d;
    logic [31:0] crc_q, crc_d;
    logic [10:0] cnt_q, cnt_d;
    logic [2:0]  fcs_rem_q, fcs_rem_d;
    logic [31:0] out_data_q, out_data_d;
    logic        out_sop_q, out_sop_d, out_eop_q, out_eop_d, out_valid_q, out_valid_d;
    logic [1:0]  out_empty_q, out_empty_d;
    logic [15:0] frame_count_q, frame_count_d;

    logic        slot_free, take;
    logic [2:0]  d_bytes, avail, pad_bytes, n_bytes;
    logic [31:0] word, base_crc, crc_n;
    logic [10:0] base_cnt, cnt_dat, cnt_n;
    int          gap;

    always_comb begin
        slot_free = !out_valid_q || out_ready;
        in_ready  = !rst && slot_free && (state_q == S_IDLE || state_q == S_PASS);
        take      = in_valid && in_ready && (state_q == S_PASS || in_startofpacket);
        base_crc  = (state_q == S_IDLE) ? 32'hFFFF_FFFF : crc_q;
        base_cnt  = (state_q == S_IDLE) ? 11'h0 : cnt_q;

        state_d       = state_q;
        crc_d         = crc_q;
        cnt_d         = cnt_q;
        fcs_rem_d     = fcs_rem_q;
        out_data_d    = out_data_q;
        out_sop_d     = out_sop_q;
        out_eop_d     = out_eop_q;
        out_empty_d   = out_empty_q;
        out_valid_d   = out_valid_q && !out_ready;
        frame_count_d = frame_count_q;
        if (out_valid_q && out_ready && out_eop_q) frame_count_d = frame_count_q + 16'h1;

        d_bytes   = 3'd4;
        avail     = 3'd0;
        pad_bytes = 3'd0;
        n_bytes   = 3'd0;
        word      = '0;
        crc_n     = crc_q;
        cnt_dat   = cnt_q;
        cnt_n     = cnt_q;
        gap       = 0;

        case (state_q)
            S_IDLE, S_PASS: begin
                if (take) begin
                    d_bytes = in_endofpacket ? (3'd4 - {1'b0, in_empty}) : 3'd4;
                    avail   = 3'd4 - d_bytes;
                    cnt_dat = sat_add(base_cnt, d_bytes);
                    // Padding starts in the spare lanes of the eop beat itself.
                    if (PAD_EN && in_endofpacket && int'(cnt_dat) < MIN_FRAME_BYTES) begin
                        gap       = MIN_FRAME_BYTES - int'(cnt_dat);
                        pad_bytes = (gap > int'(avail)) ? avail : 3'(gap);
                    end
                    n_bytes     = d_bytes + pad_bytes;
                    word        = keep_bytes(in_data, d_bytes);
                    crc_n       = crc_word(base_crc, word, n_bytes);
                    cnt_n       = sat_add(base_cnt, n_bytes);
                    crc_d       = crc_n;
                    cnt_d       = cnt_n;
                    out_valid_d = 1'b1;
                    out_sop_d   = (state_q == S_IDLE);
                    out_eop_d   = 1'b0;
                    out_empty_d = 2'd0;
                    out_data_d  = word;
                    if (!in_endofpacket) begin
                        state_d = S_PASS;
                    end else if (PAD_EN && int'(cnt_n) < MIN_FRAME_BYTES) begin
                        state_d = S_PAD;
                    end else begin
                        out_data_d = merge_fcs(word, n_bytes, ~crc_n);
                        fcs_rem_d  = n_bytes;
                        state_d    = S_FCS;
                    end
                end
            end
            S_PAD: begin
                if (slot_free) begin
                    gap         = MIN_FRAME_BYTES - int'(cnt_q);
                    n_bytes     = (gap > 4) ? 3'd4 : 3'(gap);
                    crc_n       = crc_word(crc_q, 32'h0, n_bytes);
                    cnt_n       = sat_add(cnt_q, n_bytes);
                    crc_d       = crc_n;
                    cnt_d       = cnt_n;
                    out_valid_d = 1'b1;
                    out_sop_d   = 1'b0;
                    out_eop_d   = 1'b0;
                    out_empty_d = 2'd0;
                    out_data_d  = 32'h0;
                    if (int'(cnt_n) >= MIN_FRAME_BYTES) begin
                        out_data_d = merge_fcs(32'h0, n_bytes, ~crc_n);
                        fcs_rem_d  = n_bytes;
                        state_d    = S_FCS;
                    end
                end
            end
            S_FCS: begin
                if (slot_free) begin
                    out_valid_d = 1'b1;
                    out_sop_d   = 1'b0;
                    out_eop_d   = 1'b1;
                    out_empty_d = 2'(3'd4 - fcs_rem_q);
                    out_data_d  = fcs_beat(~crc_q, fcs_rem_q);
                    crc_d       = 32'hFFFF_FFFF;
                    cnt_d       = 11'h0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            crc_q         <= 32'hFFFF_FFFF;
            cnt_q         <= 11'h0;
            fcs_rem_q     <= 3'd0;
            out_data_q    <= 32'h0;
            out_sop_q     <= 1'b0;
            out_eop_q     <= 1'b0;
            out_empty_q   <= 2'd0;
            out_valid_q   <= 1'b0;
            frame_count_q <= 16'h0;
        end else begin
            state_q       <= state_d;
            crc_q         <= crc_d;
            cnt_q         <= cnt_d;
            fcs_rem_q     <= fcs_rem_d;
            out_data_q    <= out_data_d;
            out_sop_q     <= out_sop_d;
            out_eop_q     <= out_eop_d;
            out_empty_q   <= out_empty_d;
            out_valid_q   <= out_valid_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign out_data          = out_data_q;
    assign out_startofpacket = out_sop_q;
    assign out_endofpacket   = out_eop_q;
    assign out_empty         = out_empty_q;
    assign out_valid         = out_valid_q;
    assign frame_count       = frame_count_q;

endmodule
